// File: rtl/sp_32xn_arbiter.sv
// Two-requester round-robin front end for a 32-deep single-port distributed RAM.
// Clears every word to INIT_VAL after reset, then serves valid/ready requests with registered read responses.
module sp_32xn_arbiter #(
   parameter int             DW       = 4,
   parameter logic [DW-1:0]  INIT_VAL = '0
) (
   input  logic          wclk,
   input  logic          rst,
   input  logic          req0_valid,
   input  logic          req0_we,
   input  logic [4:0]    req0_addr,
   input  logic [DW-1:0] req0_wdata,
   output logic          req0_ready,
   output logic          rsp0_valid,
   output logic [DW-1:0] rsp0_rdata,
   input  logic          req1_valid,
   input  logic          req1_we,
   input  logic [4:0]    req1_addr,
   input  logic [DW-1:0] req1_wdata,
   output logic          req1_ready,
   output logic          rsp1_valid,
   output logic [DW-1:0] rsp1_rdata,
   output logic          ram_we,
   output logic [4:0]    ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          init_done
);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [4:0] clr_cnt;
   logic       last_grant;
   logic       gnt0;
   logic       gnt1;

   // On a tie the requester that did not win last time is served, so last_grant=1 favours requester 0.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst && state == RUN) begin
         if (req0_valid && req1_valid) begin
            gnt0 = last_grant;
            gnt1 = ~last_grant;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_din   = '0;
      state_nxt = state;
      if (!rst) begin
         if (state == CLEAR) begin
            ram_we   = 1'b1;
            ram_addr = clr_cnt;
            ram_din  = INIT_VAL;
            if (clr_cnt == 5'd31) begin
               state_nxt = RUN;
            end
         end else if (gnt0) begin
            ram_we   = req0_we;
            ram_addr = req0_addr;
            ram_din  = req0_wdata;
         end else if (gnt1) begin
            ram_we   = req1_we;
            ram_addr = req1_addr;
            ram_din  = req1_wdata;
         end
      end
   end

   // Read data is captured from the combinational RAM port at the accepting edge; valid is a single-cycle pulse.
   always_ff @(posedge wclk) begin
      if (rst) begin
         state      <= CLEAR;
         clr_cnt    <= '0;
         last_grant <= 1'b1;
         init_done  <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp1_rdata <= '0;
      end else begin
         state      <= state_nxt;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 5'd1;
            if (clr_cnt == 5'd31) begin
               init_done <= 1'b1;
            end
         end
         if (req0_valid && gnt0) begin
            last_grant <= 1'b0;
            if (!req0_we) begin
               rsp0_valid <= 1'b1;
               rsp0_rdata <= ram_dout;
            end
         end
         if (req1_valid && gnt1) begin
            last_grant <= 1'b1;
            if (!req1_we) begin
               rsp1_valid <= 1'b1;
               rsp1_rdata <= ram_dout;
            end
         end
      end
   end

endmodule

// File: tb/tb_sp_32xn_arbiter.sv
// Directed bench for sp_32xn_arbiter with a behavioural 32x4 RAM attached to its RAM port.
module tb_sp_32xn_arbiter;

   logic       wclk;
   logic       rst;
   logic       req0_valid, req0_we, req0_ready, rsp0_valid;
   logic [4:0] req0_addr;
   logic [3:0] req0_wdata, rsp0_rdata;
   logic       req1_valid, req1_we, req1_ready, rsp1_valid;
   logic [4:0] req1_addr;
   logic [3:0] req1_wdata, rsp1_rdata;
   logic       ram_we, init_done;
   logic [4:0] ram_addr;
   logic [3:0] ram_din, ram_dout;
   logic [3:0] mem [32];

   int nAsserts;
   int nFails;

   sp_32xn_arbiter #(.DW(4), .INIT_VAL(4'hA)) dut (
      .wclk(wclk), .rst(rst),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .init_done(init_done)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   // Distributed RAM: combinational read, write at the clock edge.
   assign ram_dout = mem[ram_addr];
   always @(posedge wclk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
   end

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic applyStimulus(input logic v0, input logic we0, input logic [4:0] a0, input logic [3:0] d0,
                                input logic v1, input logic we1, input logic [4:0] a1, input logic [3:0] d1);
      req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
      req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      nAsserts = 0;
      nFails   = 0;
      rst      = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("rst_ram_we", ram_we, 0);
      checkOutput("rst_ready0", req0_ready, 0);
      checkOutput("rst_ready1", req1_ready, 0);
      tick();
      tick();
      checkOutput("rst_init_done", init_done, 0);
      checkOutput("rst_rsp0_valid", rsp0_valid, 0);
      checkOutput("rst_rsp1_valid", rsp1_valid, 0);
      checkOutput("rst_rsp0_rdata", rsp0_rdata, 0);
      checkOutput("rst_rsp1_rdata", rsp1_rdata, 0);

      // Clear: both requesters already asking, but must be held off for 32 cycles.
      rst = 1'b0;
      applyStimulus(1, 0, 3, 0, 1, 0, 4, 0);
      for (int i = 0; i < 32; i++) begin
         checkOutput("clr_ram_we", ram_we, 1);
         checkOutput("clr_ram_addr", ram_addr, i);
         checkOutput("clr_ram_din", ram_din, 4'hA);
         checkOutput("clr_ready0", req0_ready, 0);
         checkOutput("clr_ready1", req1_ready, 0);
         checkOutput("clr_init_done", init_done, 0);
         tick();
      end
      checkOutput("init_done_rise", init_done, 1);

      // First tie after reset: req0 write wins, req1 read of the same address follows.
      applyStimulus(1, 1, 7, 4'h9, 1, 0, 7, 0);
      checkOutput("mix_ready0", req0_ready, 1);
      checkOutput("mix_ready1_stall", req1_ready, 0);
      checkOutput("mix_ram_we", ram_we, 1);
      checkOutput("mix_ram_addr", ram_addr, 7);
      checkOutput("mix_ram_din", ram_din, 4'h9);
      tick();
      applyStimulus(0, 0, 0, 0, 1, 0, 7, 0);
      checkOutput("mix_ready1", req1_ready, 1);
      checkOutput("mix_rd_we", ram_we, 0);
      checkOutput("mix_rd_addr", ram_addr, 7);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mix_rsp1_valid", rsp1_valid, 1);
      checkOutput("mix_rsp1_rdata", rsp1_rdata, 4'h9);
      checkOutput("mix_rsp0_valid", rsp0_valid, 0);

      // Seed distinct data at addresses 1 and 2 (leaves last grant with req1).
      applyStimulus(1, 1, 1, 4'hC, 0, 0, 0, 0);
      checkOutput("wr1_ready0", req0_ready, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 1, 1, 2, 4'hD);
      checkOutput("wr2_ready1", req1_ready, 1);
      checkOutput("wr2_ram_din", ram_din, 4'hD);
      tick();
      checkOutput("wr_no_rsp0", rsp0_valid, 0);
      checkOutput("wr_no_rsp1", rsp1_valid, 0);

      // Sustained contention alternates 0,1,0,1.
      applyStimulus(1, 0, 1, 0, 1, 0, 2, 0);
      for (int k = 0; k < 4; k++) begin
         checkOutput("rr_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
         checkOutput("rr_ready1", req1_ready, (k % 2 == 1) ? 1 : 0);
         checkOutput("rr_ram_addr", ram_addr, (k % 2 == 0) ? 1 : 2);
         tick();
         checkOutput("rr_rsp0_valid", rsp0_valid, (k % 2 == 0) ? 1 : 0);
         checkOutput("rr_rsp1_valid", rsp1_valid, (k % 2 == 1) ? 1 : 0);
         if (k % 2 == 0) checkOutput("rr_rsp0_rdata", rsp0_rdata, 4'hC);
         else            checkOutput("rr_rsp1_rdata", rsp1_rdata, 4'hD);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      // Cleared location reads back INIT_VAL.
      applyStimulus(1, 0, 17, 0, 0, 0, 0, 0);
      checkOutput("rd17_ready0", req0_ready, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("rd17_rsp0_valid", rsp0_valid, 1);
      checkOutput("rd17_rsp0_rdata", rsp0_rdata, 4'hA);

      // Single requester write then read-after-write.
      applyStimulus(1, 1, 5, 4'h3, 0, 0, 0, 0);
      checkOutput("single_wr_ready0", req0_ready, 1);
      checkOutput("single_wr_we", ram_we, 1);
      tick();
      applyStimulus(1, 0, 5, 0, 0, 0, 0, 0);
      checkOutput("single_rd_ready0", req0_ready, 1);
      checkOutput("single_rd_we", ram_we, 0);
      checkOutput("single_wr_no_rsp", rsp0_valid, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("single_rsp0_valid", rsp0_valid, 1);
      checkOutput("single_rsp0_rdata", rsp0_rdata, 4'h3);
      checkOutput("single_rsp1_valid", rsp1_valid, 0);
      tick();
      checkOutput("single_rsp0_pulse", rsp0_valid, 0);
      checkOutput("single_rdata_hold", rsp0_rdata, 4'h3);

      // Idle.
      for (int k = 0; k < 10; k++) begin
         checkOutput("idle_ram_we", ram_we, 0);
         checkOutput("idle_ram_addr", ram_addr, 0);
         checkOutput("idle_ready0", req0_ready, 0);
         checkOutput("idle_ready1", req1_ready, 0);
         checkOutput("idle_rsp0", rsp0_valid, 0);
         checkOutput("idle_rsp1", rsp1_valid, 0);
         tick();
      end

      // Reset while a read is presented: no response, clear reruns.
      rst = 1'b1;
      applyStimulus(1, 0, 7, 0, 0, 0, 0, 0);
      checkOutput("midrst_ready0", req0_ready, 0);
      checkOutput("midrst_ram_we", ram_we, 0);
      tick();
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("midrst_no_rsp0", rsp0_valid, 0);
      checkOutput("midrst_init_done", init_done, 0);
      for (int i = 0; i < 32; i++) begin
         checkOutput("reclr_ram_we", ram_we, 1);
         checkOutput("reclr_ram_addr", ram_addr, i);
         tick();
      end
      checkOutput("reclr_init_done", init_done, 1);
      applyStimulus(1, 0, 7, 0, 0, 0, 0, 0);
      checkOutput("reclr_rd_ready0", req0_ready, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("reclr_rsp0_valid", rsp0_valid, 1);
      checkOutput("reclr_rsp0_rdata", rsp0_rdata, 4'hA);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
